// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg
// Shared constants and helpers for the width-down transmit FIFO.
//   WORD_W / BYTE_W : default write-word and read-byte widths
//   RATIO           : byte lanes per word
//   LANE_W          : width of the lane index
//   level_width()   : width of a level counter for a given log2 capacity
//   lane_sel()      : pick one byte lane out of a word (lane 0 = bits [7:0])
package tx_fifo_pkg;

  localparam int WORD_W = 128;
  localparam int BYTE_W = 8;
  localparam int RATIO  = WORD_W / BYTE_W;
  localparam int LANE_W = $clog2(RATIO);

  // A level must be able to hold the full capacity, hence one extra bit.
  function automatic int level_width(input int depth_w);
    return depth_w + 1;
  endfunction

  // Lane 0 is the least significant byte and is transmitted first.
  function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane);
    return word[lane*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/tx_fifo_word_ram.sv
// tx_fifo_word_ram
// Simple dual-port word memory, one clock, registered read, no array reset.
//   clk      : clock
//   wr_en    : write strobe for wr_addr/wr_data
//   rd_en    : read strobe; q updates only when asserted and holds otherwise
//   q        : registered read data
module tx_fifo_word_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; q doubles as a storage stage in front of the prefetch register.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      q <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/tx_fifo_prefetch.sv
// tx_fifo_prefetch
// Width-down FIFO: 128-bit words in, first-word-fall-through 8-bit bytes out.
//   clk, rst          : single clock, asynchronous active-high reset
//   wr_en/wr_vld      : word accepted on an edge when both are high
//   wr_data           : write word (lane 0 = bits [7:0] leaves first)
//   rd_en/rd_vld      : byte consumed on an edge when both are high
//   rd_data           : current byte (show-ahead)
//   wr_level          : words held and not yet fully consumed
//   rd_level          : bytes available (16 * wr_level - lane)
// Storage chain: RAM -> RAM output register -> prefetch register -> head register.
module tx_fifo_prefetch
  import tx_fifo_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH = 8,
  parameter int WR_DATA_WIDTH  = WORD_W,
  parameter int RD_DATA_WIDTH  = BYTE_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  output logic                             wr_vld,
  input  logic [WR_DATA_WIDTH-1:0]         wr_data,
  input  logic                             rd_en,
  output logic                             rd_vld,
  output logic [RD_DATA_WIDTH-1:0]         rd_data,
  output logic [WR_DEPTH_WIDTH:0]          wr_level,
  output logic [WR_DEPTH_WIDTH+LANE_W:0]   rd_level
);

  localparam int DEPTH          = 2**WR_DEPTH_WIDTH;
  localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + LANE_W;
  localparam int WL_W           = level_width(WR_DEPTH_WIDTH);
  localparam int RL_W           = level_width(RD_DEPTH_WIDTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Registered state
  logic [WR_DEPTH_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [WL_W-1:0]           ram_cnt_r;     // words in RAM not yet read out
  logic                      rq_vld_r;      // RAM output register holds a word
  logic [WR_DATA_WIDTH-1:0]  pf_r;
  logic                      pf_vld_r;
  logic [WR_DATA_WIDTH-1:0]  head_r;
  logic                      head_vld_r;
  logic [LANE_W-1:0]         lane_r;
  logic [WL_W-1:0]           wr_level_r;
  logic [RL_W-1:0]           rd_level_r;
  logic                      wr_vld_r;
  logic [RD_DATA_WIDTH-1:0]  rd_data_r;

  // Next-state and control
  logic [WR_DATA_WIDTH-1:0]  ram_q_s;
  logic                      wr_acc_s, cons_s, last_s, head_load_s, rq_take_s, ram_rd_s;
  logic [WL_W-1:0]           ram_cnt_nxt_s, wr_level_nxt_s;
  logic [RL_W-1:0]           rd_level_nxt_s;
  logic                      rq_vld_nxt_s, pf_vld_nxt_s, head_vld_nxt_s, wr_vld_nxt_s;
  logic [WR_DATA_WIDTH-1:0]  pf_nxt_s, head_nxt_s;
  logic [LANE_W-1:0]         lane_nxt_s;
  logic [RD_DATA_WIDTH-1:0]  rd_data_nxt_s;

  tx_fifo_word_ram #(
    .ADDR_W (WR_DEPTH_WIDTH),
    .DATA_W (WR_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_en   (ram_rd_s),
    .rd_addr (rd_ptr_r),
    .q       (ram_q_s)
  );

  // Handshakes, pipeline advance and counter next values.
  always_comb begin
    wr_acc_s    = wr_en & wr_vld_r;
    cons_s      = rd_en & head_vld_r;
    last_s      = cons_s & (lane_r == LAST_LANE);
    // Head wants a new word when empty or when its last lane leaves this edge.
    head_load_s = ~head_vld_r | last_s;
    // RAM output word moves on if the prefetch slot is free or being emptied.
    rq_take_s   = rq_vld_r & (~pf_vld_r | head_load_s);
    ram_rd_s    = (ram_cnt_r != WL_W'(0)) & (~rq_vld_r | rq_take_s);

    head_nxt_s     = head_r;
    head_vld_nxt_s = head_vld_r;
    pf_nxt_s       = pf_r;
    pf_vld_nxt_s   = pf_vld_r;

    if (head_load_s) begin
      if (pf_vld_r) begin
        head_nxt_s     = pf_r;
        head_vld_nxt_s = 1'b1;
        pf_vld_nxt_s   = rq_vld_r;
        if (rq_vld_r) begin
          pf_nxt_s = ram_q_s;
        end else begin
          pf_nxt_s = pf_r;
        end
      end else if (rq_vld_r) begin
        // Bypass the empty prefetch slot so a lone word reaches the head quickly.
        head_nxt_s     = ram_q_s;
        head_vld_nxt_s = 1'b1;
      end else begin
        head_vld_nxt_s = 1'b0;
      end
    end else begin
      if (!pf_vld_r && rq_vld_r) begin
        pf_nxt_s     = ram_q_s;
        pf_vld_nxt_s = 1'b1;
      end else begin
        pf_vld_nxt_s = pf_vld_r;
      end
    end

    // Lane index wraps 15 -> 0 naturally at the word boundary.
    if (cons_s) begin
      lane_nxt_s = lane_r + LANE_W'(1'b1);
    end else begin
      lane_nxt_s = lane_r;
    end

    if (ram_rd_s) begin
      rq_vld_nxt_s = 1'b1;
    end else if (rq_take_s) begin
      rq_vld_nxt_s = 1'b0;
    end else begin
      rq_vld_nxt_s = rq_vld_r;
    end

    ram_cnt_nxt_s  = ram_cnt_r + WL_W'(wr_acc_s) - WL_W'(ram_rd_s);
    wr_level_nxt_s = wr_level_r + WL_W'(wr_acc_s) - WL_W'(last_s);
    if (wr_acc_s) begin
      rd_level_nxt_s = rd_level_r + RL_W'(RATIO) - RL_W'(cons_s);
    end else begin
      rd_level_nxt_s = rd_level_r - RL_W'(cons_s);
    end
    wr_vld_nxt_s  = (wr_level_nxt_s < WL_W'(DEPTH));
    rd_data_nxt_s = lane_sel(head_nxt_s, lane_nxt_s);
  end

  // State register for pointers, counters, pipeline stages and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      ram_cnt_r  <= '0;
      rq_vld_r   <= 1'b0;
      pf_r       <= '0;
      pf_vld_r   <= 1'b0;
      head_r     <= '0;
      head_vld_r <= 1'b0;
      lane_r     <= '0;
      wr_level_r <= '0;
      rd_level_r <= '0;
      wr_vld_r   <= 1'b1;
      rd_data_r  <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + WR_DEPTH_WIDTH'(1'b1);
      end
      if (ram_rd_s) begin
        rd_ptr_r <= rd_ptr_r + WR_DEPTH_WIDTH'(1'b1);
      end
      ram_cnt_r  <= ram_cnt_nxt_s;
      rq_vld_r   <= rq_vld_nxt_s;
      pf_r       <= pf_nxt_s;
      pf_vld_r   <= pf_vld_nxt_s;
      head_r     <= head_nxt_s;
      head_vld_r <= head_vld_nxt_s;
      lane_r     <= lane_nxt_s;
      wr_level_r <= wr_level_nxt_s;
      rd_level_r <= rd_level_nxt_s;
      wr_vld_r   <= wr_vld_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
    end
  end

  assign wr_vld   = wr_vld_r;
  assign rd_vld   = head_vld_r;
  assign rd_data  = rd_data_r;
  assign wr_level = wr_level_r;
  assign rd_level = rd_level_r;

endmodule

// File: tb/tb_tx_fifo_prefetch.sv
module tb_tx_fifo_prefetch;

  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         wr_vld;
  logic [127:0] wr_data;
  logic         rd_en;
  logic         rd_vld;
  logic [7:0]   rd_data;
  logic [8:0]   wr_level;
  logic [12:0]  rd_level;

  tx_fifo_prefetch dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .wr_level (wr_level),
    .rd_level (rd_level)
  );

  always #5 clk = ~clk;

  // Reference model: queue of words (with the edge that accepted each) and
  // the number of bytes already taken from the oldest word.
  logic [127:0] mq[$];
  int           mcyc[$];
  int           mlane = 0;
  int           cyc = 0;
  int           bytes_out = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  // A byte is visible once the oldest held word was accepted two or more edges ago.
  function automatic bit model_vld();
    if (mq.size() == 0) return 1'b0;
    return (mcyc[0] <= cyc - 2);
  endfunction

  task automatic compare_all();
    logic [127:0] w;
    check_eq("wr_vld", wr_vld, (mq.size() < DEPTH));
    check_eq("rd_vld", rd_vld, model_vld());
    if (model_vld()) begin
      w = mq[0];
      check_eq("rd_data", rd_data, w[mlane*8 +: 8]);
    end
    check_eq("wr_level", wr_level, mq.size());
    check_eq("rd_level", rd_level, mq.size() * 16 - mlane);
  endtask

  task automatic step(input logic we, input logic [127:0] wd, input logic re);
    bit acc, cons;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    acc  = we && (mq.size() < DEPTH);
    cons = re && model_vld();
    @(posedge clk);
    cyc++;
    if (cons) begin
      bytes_out++;
      mlane++;
      if (mlane == 16) begin
        void'(mq.pop_front());
        void'(mcyc.pop_front());
        mlane = 0;
      end
    end
    if (acc) begin
      mq.push_back(wd);
      mcyc.push_back(cyc);
    end
    #1;
    compare_all();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain(input int max_cycles);
    int k = 0;
    while (mq.size() > 0 && k < max_cycles) begin
      step(1'b0, '0, 1'b1);
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_wr_vld"}, wr_vld, 1'b1);
    check_eq({pfx, "_rd_vld"}, rd_vld, 1'b0);
    check_eq({pfx, "_rd_data"}, rd_data, 8'h00);
    check_eq({pfx, "_wr_level"}, wr_level, 9'd0);
    check_eq({pfx, "_rd_level"}, rd_level, 13'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w1, w2;
    int valid_cnt;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Single-word latency; the read issued while empty is ignored.
    w1 = 128'h0F0E0D0C0B0A09080706050403020100;
    step(1'b1, w1, 1'b1);
    step(1'b0, '0, 1'b1);
    check_eq("lat_t1_rd_vld", rd_vld, 1'b0);
    step(1'b0, '0, 1'b1);
    check_eq("lat_t2_rd_vld", rd_vld, 1'b1);
    check_eq("lat_t2_rd_data", rd_data, 8'h00);
    repeat (18) step(1'b0, '0, 1'b1);
    check_eq("single_empty_level", wr_level, 9'd0);

    // Seamless streaming of four preloaded words.
    repeat (4) step(1'b1, rand_word(), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    valid_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, '0, 1'b1);
      if (i < 63 && rd_vld) valid_cnt++;
    end
    check_eq("stream_no_gap", valid_cnt, 63);
    check_eq("stream_end_vld", rd_vld, 1'b0);

    // Fill to full, extra writes dropped, then the full/final-byte boundary.
    bytes_out = 0;
    repeat (256) step(1'b1, rand_word(), 1'b0);
    check_eq("full_wr_vld", wr_vld, 1'b0);
    repeat (5) step(1'b1, rand_word(), 1'b0);
    check_eq("full_level", wr_level, 9'd256);
    repeat (16) step(1'b0, '0, 1'b1);
    check_eq("after16_wr_vld", wr_vld, 1'b1);
    check_eq("after16_level", wr_level, 9'd255);
    step(1'b1, rand_word(), 1'b0);
    check_eq("refill_level", wr_level, 9'd256);
    repeat (15) step(1'b0, '0, 1'b1);
    step(1'b1, rand_word(), 1'b1);
    check_eq("simul_full_level", wr_level, 9'd255);
    step(1'b1, rand_word(), 1'b0);
    check_eq("retry_level", wr_level, 9'd256);
    drain(5000);
    check_eq("fill_bytes_out", bytes_out, 258 * 16);

    // Asynchronous reset mid-stream with three words held.
    repeat (3) step(1'b1, rand_word(), 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete(); mcyc.delete(); mlane = 0;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #2 rst = 1'b0;
    w2 = rand_word();
    step(1'b1, w2, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_eq("post_rst_first_byte", rd_data, w2[7:0]);
    drain(100);

    // Random soak: low write rate for several pointer wraps, then a congested phase.
    for (int i = 0; i < 14000; i++) begin
      step(($urandom_range(0, 13) == 0), rand_word(), ($urandom_range(0, 15) != 0));
    end
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 1) == 0), rand_word(), ($urandom_range(0, 1) == 0));
    end
    drain(5000);
    check_eq("soak_empty_level", wr_level, 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
